// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared main-memory constants and read-pipeline entry type
//
// Imported by the responder, the arbitrator and the cache FSMs. Because they
// all share one latency constant, their timing assumptions stay aligned.
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int MEM_LATENCY = 4;
    localparam int OUTST_W     = 4;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between arbitrator and memory responder
//
// master: arbitrator side (drives enable/wr/addr/data_in)
// slave : memory side     (drives data_out/data_valid/outstanding)
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) ();

    logic               enable;
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [WORD_W-1:0]  data_in;
    logic [WORD_W-1:0]  data_out;
    logic               data_valid;
    logic [OUTST_W-1:0] outstanding;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - fixed-depth valid/data shift pipeline for read returns
//
// Ports:
//   clk, rst : clock, asynchronous active-high clear of every stage
//   push     : entry entering stage 0 on each rising edge
//   head     : entry in stage DEPTH-1
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t push,
    output pipe_entry_t head
);

    pipe_entry_t stage [DEPTH];

    // Empty slots carry zero data, so an idle output reads 0, not stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - unified main-memory responder with fixed read latency
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset (pipeline and counter only)
//   bus : slave side of mem_responder_if
//         enable/wr/addr/data_in   request, accepted every edge with enable=1
//         data_out/data_valid      read return, LATENCY edges after acceptance
//         outstanding              reads accepted but not yet returned
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_W     = 16,
    parameter int    DEPTH_LOG2 = 15,
    parameter int    LATENCY    = MEM_LATENCY,
    parameter string INIT_FILE  = ""
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int NWORDS = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] mem [NWORDS];

    // Byte address to word index; index bits above DEPTH_LOG2 alias.
    logic [ADDR_W-2:0]     word_addr;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_addr_lsb;

    assign word_addr       = bus.addr[ADDR_W-1:1];
    assign idx             = word_addr[DEPTH_LOG2-1:0];
    assign unused_addr_lsb = bus.addr[0];

    logic rd_accept;
    logic wr_accept;

    assign rd_accept = bus.enable & ~bus.wr;
    assign wr_accept = bus.enable &  bus.wr;

    // Array is deliberately not reset. A read on the same edge sees the
    // pre-write contents, which gives read-after-write ordering across cycles.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[idx] <= bus.data_in;
        end
    end

    pipe_entry_t push;
    pipe_entry_t head;

    always_comb begin
        push.valid = rd_accept;
        push.data  = rd_accept ? mem[idx] : '0;
    end

    mem_rd_pipe #(
        .DEPTH (LATENCY)
    ) u_rd_pipe (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .head (head)
    );

    assign bus.data_valid = head.valid;
    assign bus.data_out   = head.data;

    // A read stays counted through its data_valid cycle; it is bounded by
    // LATENCY because the pipe holds at most LATENCY entries.
    logic [OUTST_W-1:0] outstanding_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            case ({rd_accept, head.valid})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16)) bus ();

    mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int peak  = 0;

    logic [15:0] model [int];
    int          rq_due  [$];
    logic [15:0] rq_data [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive request, let the edge take it, update model, check at negedge.
    task automatic cycle(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          idx;
        logic        exp_v;
        logic [15:0] exp_d;
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        cyc++;
        idx = int'(a >> 1);
        if (en && w) begin
            model[idx] = d;
        end else if (en) begin
            rq_due.push_back(cyc + LAT - 1);
            rq_data.push_back(model.exists(idx) ? model[idx] : 16'hxxxx);
        end
        @(negedge clk);
        while (rq_due.size() > 0 && rq_due[0] < cyc) begin
            void'(rq_due.pop_front());
            void'(rq_data.pop_front());
        end
        exp_v = (rq_due.size() > 0) && (rq_due[0] == cyc);
        exp_d = exp_v ? rq_data[0] : 16'h0000;
        chk("data_valid",  {31'd0, bus.data_valid}, {31'd0, exp_v});
        chk("data_out",    {16'd0, bus.data_out},   {16'd0, exp_d});
        chk("outstanding", {28'd0, bus.outstanding}, rq_due.size());
        if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_data_valid",  {31'd0, bus.data_valid},  32'd0);
        chk("rst_data_out",    {16'd0, bus.data_out},    32'd0);
        chk("rst_outstanding", {28'd0, bus.outstanding}, 32'd0);
        rst = 1'b0;

        // Write then read next cycle
        cycle(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        cycle(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("beef_outst_first", {28'd0, bus.outstanding}, 32'd1);
        idle(LAT + 1);
        chk("beef_outst_end", {28'd0, bus.outstanding}, 32'd0);

        // Back-to-back reads
        cycle(1'b1, 1'b1, 16'h0000, 16'd1);
        cycle(1'b1, 1'b1, 16'h0002, 16'd2);
        cycle(1'b1, 1'b1, 16'h0004, 16'd3);
        cycle(1'b1, 1'b1, 16'h0006, 16'd4);
        peak = 0;
        cycle(1'b1, 1'b0, 16'h0000, 16'h0);
        cycle(1'b1, 1'b0, 16'h0002, 16'h0);
        cycle(1'b1, 1'b0, 16'h0004, 16'h0);
        cycle(1'b1, 1'b0, 16'h0006, 16'h0);
        idle(LAT + 2);
        chk("b2b_peak", peak, 32'd4);

        // Read followed by write to the same word
        cycle(1'b1, 1'b1, 16'h0020, 16'h1111);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0000);
        cycle(1'b1, 1'b1, 16'h0020, 16'h2222);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(LAT + 1);

        // Reset with reads in flight
        cycle(1'b1, 1'b0, 16'h0000, 16'h0);
        cycle(1'b1, 1'b0, 16'h0002, 16'h0);
        cycle(1'b1, 1'b0, 16'h0004, 16'h0);
        idle(2);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.data_valid},  32'd0);
        chk("async_rst_outst", {28'd0, bus.outstanding}, 32'd0);
        rq_due.delete();
        rq_data.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(8);

        // Byte-address bit 0 ignored
        cycle(1'b1, 1'b1, 16'h0001, 16'hA5A5);
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000);
        idle(LAT + 1);

        // Disabled write attempts leave the array alone
        cycle(1'b1, 1'b1, 16'h0040, 16'h1234);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h0040, 16'hFFFF);
        cycle(1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(LAT + 1);

        // Randomised traffic over a small preloaded window
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 16'h0100 + 16'(i * 2), 16'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            logic        en;
            logic        w;
            logic [15:0] a;
            en = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            a  = 16'h0100 + 16'($urandom_range(0, 15) * 2) + 16'($urandom_range(0, 1));
            cycle(en, w, a, 16'($urandom));
        end
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
